// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter bank: core event line indices,
// the disabled-select encoding and the per-counter overflow mode encodings.
package perf_pkg;

  localparam int EV_RETIRED = 0;
  localparam int EV_STALL   = 1;
  localparam int EV_BUBBLE  = 2;
  localparam int EV_FLUSH   = 3;
  localparam int EV_RAW     = 4;
  localparam int EV_FWD     = 5;
  localparam int EV_CBR     = 6;
  localparam int EV_UBR     = 7;
  localparam int EV_ALU_R   = 8;
  localparam int EV_ALU_I   = 9;
  localparam int EV_LOAD    = 10;
  localparam int EV_STORE   = 11;
  localparam int EV_JUMP    = 12;
  localparam int EV_SYSTEM  = 13;

  localparam int NUM_EVENTS_DEF = 16;
  localparam int SEL_W_DEF      = $clog2(NUM_EVENTS_DEF) + 1;

  // Any select with the MSB set is out of event range; all-ones is the canonical "off" value.
  localparam logic [SEL_W_DEF-1:0] SEL_DISABLED = '1;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/perf_counter_slice.sv
// One programmable counter: its event select/mode/irq-enable config, the live
// count, a sticky overflow flag and a shadow register loaded on snap.
module perf_counter_slice
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_W      = $clog2(NUM_EVENTS) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  active,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  clear,
  input  logic                  snap,
  input  logic                  cfg_we,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic                  cfg_sat,
  input  logic                  cfg_irq_en,
  output logic [CNT_WIDTH-1:0]  shadow,
  output logic                  ovf,
  output logic                  irq_en
);

  logic [SEL_W-1:0]      sel;
  logic                  sat;
  logic [CNT_WIDTH-1:0]  count;
  logic [NUM_EVENTS-1:0] ev_shift;
  logic                  hit;

  // Shifting past the vector width yields zero, so out-of-range selects never hit.
  assign ev_shift = events >> sel;
  assign hit      = active & ev_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel    <= '1;
      sat    <= MODE_WRAP;
      irq_en <= 1'b0;
      count  <= '0;
      ovf    <= 1'b0;
      shadow <= '0;
    end else begin
      if (snap) shadow <= count;
      if (cfg_we) begin
        sel    <= cfg_sel;
        sat    <= cfg_sat;
        irq_en <= cfg_irq_en;
      end
      // Reprogramming restarts the counter so old and new event counts never mix.
      if (clear || cfg_we) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (hit) begin
        if (&count) begin
          ovf <= 1'b1;
          if (sat == MODE_WRAP) count <= '0;
        end else begin
          count <= count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of programmable event counters plus a free-running cycle counter, with
// atomic snapshot into shadows, a one-cycle-latency read port and overflow irq.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS   = 16,
  parameter int NUM_COUNTERS = 8,
  parameter int CNT_WIDTH    = 32,
  parameter int SEL_W        = $clog2(NUM_EVENTS) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              perf_enable,
  input  logic [NUM_EVENTS-1:0]             events,
  input  logic                              clear,
  input  logic                              freeze,
  input  logic                              snap,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_COUNTERS)-1:0]   cfg_idx,
  input  logic [SEL_W-1:0]                  cfg_sel,
  input  logic                              cfg_sat,
  input  logic                              cfg_irq_en,
  input  logic                              rd_req,
  input  logic [$clog2(NUM_COUNTERS+1)-1:0] rd_idx,
  output logic                              rd_valid,
  output logic [CNT_WIDTH-1:0]              rd_data,
  output logic                              rd_err,
  output logic [NUM_COUNTERS-1:0]           ovf_flags,
  output logic                              irq
);

  localparam int IDX_W = $clog2(NUM_COUNTERS);
  localparam int RD_W  = $clog2(NUM_COUNTERS + 1);
  localparam logic [RD_W-1:0] RD_CYCLE = RD_W'(NUM_COUNTERS);

  logic                    active;
  logic [CNT_WIDTH-1:0]    shadow [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] irq_en;
  logic [CNT_WIDTH-1:0]    cycle_cnt;
  logic [CNT_WIDTH-1:0]    cycle_shadow;

  assign active = perf_enable & ~freeze & ~clear;

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
    perf_counter_slice #(
      .NUM_EVENTS (NUM_EVENTS),
      .CNT_WIDTH  (CNT_WIDTH),
      .SEL_W      (SEL_W)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .active     (active),
      .events     (events),
      .clear      (clear),
      .snap       (snap),
      .cfg_we     (cfg_we && (cfg_idx == IDX_W'(i))),
      .cfg_sel    (cfg_sel),
      .cfg_sat    (cfg_sat),
      .cfg_irq_en (cfg_irq_en),
      .shadow     (shadow[i]),
      .ovf        (ovf_flags[i]),
      .irq_en     (irq_en[i])
    );
  end

  // The cycle counter always wraps and never flags overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt    <= '0;
      cycle_shadow <= '0;
    end else begin
      if (snap) cycle_shadow <= cycle_cnt;
      if (clear)       cycle_cnt <= '0;
      else if (active) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      irq      <= |(ovf_flags & irq_en);
      if (rd_req) begin
        if (rd_idx < RD_CYCLE)       rd_data <= shadow[rd_idx[IDX_W-1:0]];
        else if (rd_idx == RD_CYCLE) rd_data <= cycle_shadow;
        else                         rd_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank with 8-bit counters: table-driven reads
// and event patterns plus hand-written overflow, priority and read-port sequences.
module tb_perf_counter_bank;
  import perf_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        perf_enable;
  logic [15:0] events;
  logic        clear;
  logic        freeze;
  logic        snap;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [4:0]  cfg_sel;
  logic        cfg_sat;
  logic        cfg_irq_en;
  logic        rd_req;
  logic [3:0]  rd_idx;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_err;
  logic [7:0]  ovf_flags;
  logic        irq;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        pe;
    logic [15:0] ev;
  } stim_t;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] exp_data;
    logic       exp_err;
  } rd_vec_t;

  stim_t   count_tab [10];
  rd_vec_t rd_tab [7];

  perf_counter_bank #(
    .NUM_EVENTS   (16),
    .NUM_COUNTERS (8),
    .CNT_WIDTH    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .perf_enable (perf_enable),
    .events      (events),
    .clear       (clear),
    .freeze      (freeze),
    .snap        (snap),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_sel     (cfg_sel),
    .cfg_sat     (cfg_sat),
    .cfg_irq_en  (cfg_irq_en),
    .rd_req      (rd_req),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .ovf_flags   (ovf_flags),
    .irq         (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    perf_enable = s.pe;
    events      = s.ev;
  endtask

  task automatic do_cfg(input int idx, input logic [4:0] sel, input logic sat, input logic ien);
    cfg_idx    = 3'(idx);
    cfg_sel    = sel;
    cfg_sat    = sat;
    cfg_irq_en = ien;
    cfg_we     = 1'b1;
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  task automatic do_read(input string name, input int idx, input logic [7:0] exp_data, input logic exp_err);
    rd_req = 1'b1;
    rd_idx = 4'(idx);
    step();
    rd_req = 1'b0;
    checkOutput({name, " valid"}, 32'(rd_valid), 32'd1);
    checkOutput({name, " data"}, 32'(rd_data), 32'(exp_data));
    checkOutput({name, " err"}, 32'(rd_err), 32'(exp_err));
  endtask

  initial begin
    count_tab[0] = '{1'b1, 16'h0002};
    count_tab[1] = '{1'b1, 16'h0001};
    count_tab[2] = '{1'b1, 16'h0002};
    count_tab[3] = '{1'b1, 16'h0002};
    count_tab[4] = '{1'b1, 16'h0000};
    count_tab[5] = '{1'b1, 16'h0003};
    count_tab[6] = '{1'b1, 16'h0000};
    count_tab[7] = '{1'b1, 16'h0002};
    count_tab[8] = '{1'b1, 16'h0001};
    count_tab[9] = '{1'b1, 16'h0000};

    rd_tab[0] = '{4'd3,  8'd104, 1'b0};
    rd_tab[1] = '{4'd4,  8'd102, 1'b0};
    rd_tab[2] = '{4'd9,  8'd0,   1'b1};
    rd_tab[3] = '{4'd5,  8'd0,   1'b0};
    rd_tab[4] = '{4'd6,  8'd0,   1'b0};
    rd_tab[5] = '{4'd0,  8'd101, 1'b0};
    rd_tab[6] = '{4'd15, 8'd0,   1'b1};

    rst_n = 1'b0; perf_enable = 1'b0; events = '0; clear = 1'b0; freeze = 1'b0;
    snap = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_sat = 1'b0;
    cfg_irq_en = 1'b0; rd_req = 1'b0; rd_idx = '0;

    // Reset state, then a reset asserted mid-count with a read in flight
    repeat (2) step();
    checkOutput("reset ovf", 32'(ovf_flags), 32'd0);
    checkOutput("reset irq", 32'(irq), 32'd0);
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset rd_data", 32'(rd_data), 32'd0);
    checkOutput("reset rd_err", 32'(rd_err), 32'd0);
    rst_n = 1'b1;
    do_cfg(0, 5'(EV_RETIRED), MODE_WRAP, 1'b0);
    perf_enable = 1'b1; events = 16'h0001;
    repeat (5) step();
    rd_req = 1'b1; rd_idx = 4'd0;
    step();
    rd_req = 1'b0; rst_n = 1'b0; perf_enable = 1'b0; events = '0;
    #1;
    checkOutput("async reset rd_valid", 32'(rd_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("post-release rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("post-release ovf", 32'(ovf_flags), 32'd0);
    checkOutput("post-release irq", 32'(irq), 32'd0);
    do_snap();
    for (int i = 0; i <= 8; i++) do_read($sformatf("reset read %0d", i), i, 8'd0, 1'b0);

    // Basic counting on EV_STALL, 5 strobes over 10 enabled cycles
    do_cfg(0, 5'(EV_STALL), MODE_WRAP, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(count_tab[i]);
      step();
    end
    perf_enable = 1'b0; events = '0;
    do_snap();
    do_read("basic cnt0", 0, 8'd5, 1'b0);
    do_read("basic cycle", 8, 8'd10, 1'b0);

    // Freeze, then disable, then resume
    perf_enable = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      events = (i % 2 == 0) ? 16'h0002 : 16'h0000;
      step();
    end
    freeze = 1'b0; perf_enable = 1'b0; events = '0;
    do_snap();
    do_read("freeze cnt0", 0, 8'd5, 1'b0);
    do_read("freeze cycle", 8, 8'd10, 1'b0);
    events = 16'h0002;
    repeat (3) step();
    events = '0;
    do_snap();
    do_read("disabled cnt0", 0, 8'd5, 1'b0);
    do_read("disabled cycle", 8, 8'd10, 1'b0);
    perf_enable = 1'b1; events = 16'h0002;
    repeat (3) step();
    perf_enable = 1'b0; events = '0;
    do_snap();
    do_read("resume cnt0", 0, 8'd8, 1'b0);
    do_read("resume cycle", 8, 8'd13, 1'b0);

    // Wrap vs saturate, overflow flags and registered irq
    clear = 1'b1; step(); clear = 1'b0;
    do_cfg(1, 5'(EV_RETIRED), MODE_WRAP, 1'b0);
    do_cfg(2, 5'(EV_RETIRED), MODE_SAT, 1'b1);
    perf_enable = 1'b1; events = 16'h0001;
    repeat (255) step();
    checkOutput("pre-ovf flags", 32'(ovf_flags), 32'h00);
    checkOutput("pre-ovf irq", 32'(irq), 32'd0);
    step();
    checkOutput("ovf flags at 256th", 32'(ovf_flags), 32'h06);
    checkOutput("irq not yet", 32'(irq), 32'd0);
    step();
    checkOutput("irq one cycle later", 32'(irq), 32'd1);
    perf_enable = 1'b0; events = '0;
    do_snap();
    do_read("wrap cnt1", 1, 8'd1, 1'b0);
    do_read("sat cnt2", 2, 8'd255, 1'b0);
    do_read("wrapped cycle", 8, 8'd1, 1'b0);
    do_cfg(2, 5'(EV_RETIRED), MODE_SAT, 1'b0);
    checkOutput("cfg clears flag2", 32'(ovf_flags), 32'h02);
    checkOutput("irq lags cfg", 32'(irq), 32'd1);
    step();
    checkOutput("irq masked cnt1", 32'(irq), 32'd0);

    // clear + snap priority, cfg_we discards a coincident increment
    clear = 1'b1; step(); clear = 1'b0;
    checkOutput("clear flags", 32'(ovf_flags), 32'h00);
    perf_enable = 1'b1; events = 16'h0002;
    repeat (7) step();
    clear = 1'b1; snap = 1'b1;
    step();
    clear = 1'b0; snap = 1'b0; perf_enable = 1'b0; events = '0;
    do_read("clear+snap shadow0", 0, 8'd7, 1'b0);
    do_read("clear+snap cycle", 8, 8'd7, 1'b0);
    do_snap();
    do_read("cleared live0", 0, 8'd0, 1'b0);
    do_read("cleared cycle", 8, 8'd0, 1'b0);
    perf_enable = 1'b1; events = 16'h0002;
    repeat (3) step();
    do_cfg(0, 5'(EV_STALL), MODE_WRAP, 1'b0);
    step();
    perf_enable = 1'b0; events = '0;
    do_snap();
    do_read("cfg discards inc", 0, 8'd1, 1'b0);

    // Read port: back-to-back table reads including out-of-range indices
    do_cfg(3, 5'(EV_LOAD), MODE_WRAP, 1'b0);
    do_cfg(4, 5'(EV_STORE), MODE_WRAP, 1'b0);
    do_cfg(5, SEL_DISABLED, MODE_WRAP, 1'b0);
    perf_enable = 1'b1;
    events = 16'h0C00; repeat (2) step();
    events = 16'h0400; repeat (2) step();
    events = 16'hFFFF; repeat (100) step();
    perf_enable = 1'b0; events = '0;
    do_snap();
    checkOutput("no ovf after bulk", 32'(ovf_flags), 32'h00);
    for (int i = 0; i < 7; i++) begin
      rd_req = 1'b1;
      rd_idx = rd_tab[i].idx;
      step();
      checkOutput($sformatf("b2b valid %0d", i), 32'(rd_valid), 32'd1);
      checkOutput($sformatf("b2b data %0d", i), 32'(rd_data), 32'(rd_tab[i].exp_data));
      checkOutput($sformatf("b2b err %0d", i), 32'(rd_err), 32'(rd_tab[i].exp_err));
    end
    rd_req = 1'b0;
    step();
    checkOutput("rd_valid single pulse", 32'(rd_valid), 32'd0);

    // A snap coinciding with a read is not visible in that read
    perf_enable = 1'b1; events = 16'h0400;
    step();
    perf_enable = 1'b0; events = '0;
    rd_req = 1'b1; rd_idx = 4'd3; snap = 1'b1;
    step();
    snap = 1'b0;
    checkOutput("read hides same-cycle snap", 32'(rd_data), 32'd104);
    step();
    rd_req = 1'b0;
    checkOutput("read sees prior snap", 32'(rd_data), 32'd105);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised, programmable performance-counter bank. It replaces the fixed per-metric counters with NUM_COUNTERS generic counters, each mapped at run time to one of NUM_EVENTS core event lines, plus one free-running cycle counter. Adds per-counter wrap/saturate mode, sticky overflow with interrupt, atomic snapshot into shadow registers, and a registered read port. The block sits beside the core pipeline; the core supplies one-cycle event strobes and the debug/testbench side reads the results.

Parameters:
NUM_EVENTS, 16, width of the event strobe vector (event index 0..NUM_EVENTS-1)
NUM_COUNTERS, 8, number of programmable counters (index 0..NUM_COUNTERS-1)
CNT_WIDTH, 32, width of every counter and its shadow register (minimum 4)
SEL_W, $clog2(NUM_EVENTS)+1, width of the event-select field (derived; MSB=1 means disabled)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
perf_enable  in  1  global count enable
events  in  NUM_EVENTS  event strobes, one count per cycle per asserted bit
clear  in  1  synchronous zeroing of all counters, cycle counter and overflow flags
freeze  in  1  hold all counters (level)
snap  in  1  copy live counters into shadows (pulse)
cfg_we  in  1  configuration write strobe
cfg_idx  in  $clog2(NUM_COUNTERS)  counter being configured
cfg_sel  in  SEL_W  event select for that counter
cfg_sat  in  1  1 = saturate, 0 = wrap
cfg_irq_en  in  1  overflow interrupt enable for that counter
rd_req  in  1  read request
rd_idx  in  $clog2(NUM_COUNTERS+1)  0..NUM_COUNTERS-1 = counter shadows, NUM_COUNTERS = cycle shadow
rd_valid  out  1  read data valid
rd_data  out  CNT_WIDTH  shadow value
rd_err  out  1  rd_idx out of range
ovf_flags  out  NUM_COUNTERS  sticky overflow flags
irq  out  1  OR of (ovf_flags & irq_en)

Behaviour:
- Reset (rst_n low, asynchronous): all counters, shadows and ovf_flags = 0; every sel = all-ones (disabled); sat = 0; irq_en = 0; rd_valid = 0, rd_data = 0, rd_err = 0, irq = 0. A mid-operation reset drops any pending read; rd_valid is 0 on the first edge after release.
- Count condition: active = perf_enable & ~freeze & ~clear. When active, the cycle counter increments every cycle, and counter i increments when sel_i < NUM_EVENTS and events[sel_i] = 1.
- The cycle counter always wraps and has no overflow flag.
- Overflow: an increment taken at all-ones sets ovf_flags[i] (sticky). In wrap mode the counter becomes 0. In saturate mode the counter holds at all-ones and the flag is still set.
- irq is registered, so it rises one cycle after the flag.
- clear has priority over increment and snap capture: counters and flags are 0 on the next edge. Shadows are untouched by clear.
- cfg_we writes sel/sat/irq_en for cfg_idx. The same edge zeroes that counter and its overflow flag, discarding any coincident increment. The new select takes effect from the following cycle. cfg_idx >= NUM_COUNTERS is ignored.
- snap: on the edge where snap = 1, each shadow takes the live counter value before that cycle's increment. snap together with clear captures the pre-clear values.
- Read: rd_req in cycle T gives rd_valid = 1 in T+1 for exactly one cycle, with rd_data = shadow value as it stood in cycle T. A snap in the same cycle is not visible.
- Back-to-back requests are allowed, one per cycle, with no backpressure.
- rd_idx > NUM_COUNTERS: rd_data = 0 and rd_err = 1 with rd_valid.
- Increment width is exactly 1 per cycle per counter; no multi-event accumulation.

Decomposition:
- Shared package perf_pkg holds:
  - event index constants: EV_RETIRED=0, EV_STALL=1, EV_BUBBLE=2, EV_FLUSH=3, EV_RAW=4, EV_FWD=5, EV_CBR=6, EV_UBR=7, EV_ALU_R=8, EV_ALU_I=9, EV_LOAD=10, EV_STORE=11, EV_JUMP=12, EV_SYSTEM=13
  - SEL_DISABLED (all-ones select value)
  - mode encodings MODE_WRAP=0, MODE_SAT=1
- One sub-module, perf_counter_slice: one counter, its config registers, its overflow flag and its shadow. It is instantiated NUM_COUNTERS times in a generate loop. Read mux and irq reduction stay in the top.

Test Plan:
- Reset values: rst_n low mid-count, then release -> all ovf_flags = 0, irq = 0, rd_valid = 0. A read of every index after snap returns 0.
- Basic count: program counter 0 with sel = EV_STALL, perf_enable = 1, stall strobed 5 of 10 cycles, then snap, then read idx 0 and idx NUM_COUNTERS -> rd_data = 5, and cycle = 10 counted from the cycle after cfg_we.
- Wrap vs saturate (CNT_WIDTH = 8): counters 1 (wrap) and 2 (sat) both on EV_RETIRED, 257 strobes -> counter 1 = 1, counter 2 = 255, ovf_flags[2:1] = 2'b11. With irq_en only on counter 2, irq rises one cycle after the 256th strobe.
- Priority: clear and snap in the same cycle with counter 0 = 7 -> shadow 0 = 7 and live counter 0 = 0. cfg_we on a counter during its event strobe -> counter = 0.
- Freeze/enable: freeze high for 4 cycles while events toggle -> counters unchanged. perf_enable low -> cycle counter unchanged.
- Read port: rd_req with idx 3,4,NUM_COUNTERS+1 on consecutive cycles -> three consecutive rd_valid pulses, the last with rd_err = 1 and rd_data = 0. A disabled counter (sel = SEL_DISABLED) reads 0 after 100 event cycles.
